// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets
// and the bit layout of the CONSOLE status word.
package dmem_pkg;

  localparam logic [7:0] TOHOST_OFS  = 8'h00;
  localparam logic [7:0] CONSOLE_OFS = 8'h04;
  localparam logic [7:0] CYCLE_OFS   = 8'h08;

  localparam int ST_FULL_BIT   = 0;
  localparam int ST_EMPTY_BIT  = 1;
  localparam int ST_OVF_BIT    = 2;
  localparam int ST_COUNT_LSB  = 3;

endpackage

// File: rtl/dmem_sync_fifo.sv
// Synchronous FIFO with a registered head byte; a push while full is only
// accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
)(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] head_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [AW-1:0]    rd_next_s;

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;
  assign dout  = head_r;

  // Accept/advance decisions for this cycle.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    if (pop_ok_s) begin
      rd_next_s = rd_ptr_r + AW'(1);
    end else begin
      rd_next_s = rd_ptr_r;
    end
  end

  // Storage array; no reset needed since head_r gates what is visible.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
    end else begin
      rd_ptr_r <= rd_next_s;
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      count_r <= count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
      // The head moves only on a pop or on the first entry into an empty FIFO.
      if (pop_ok_s || (push_ok_s && empty)) begin
        head_r <= (push_ok_s && (wr_ptr_r == rd_next_s)) ? din : mem_r[rd_next_s];
      end
    end
  end

endmodule

// File: rtl/dmem.sv
// Data-memory responder: byte-strobed RAM plus an MMIO window holding the
// TOHOST halt register, a console FIFO and a free-running cycle counter.
module dmem
  import dmem_pkg::*;
#(
  parameter int                XLEN       = 32,
  parameter int                DEPTH      = 4096,
  parameter logic [XLEN-1:0]   MMIO_BASE  = 32'hFFFF_FF00,
  parameter int                FIFO_DEPTH = 8
)(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [XLEN-1:0]      mem_addr,
  input  logic [XLEN/8-1:0]    mem_r,
  input  logic [XLEN/8-1:0]    mem_w,
  input  logic [XLEN-1:0]      mem_din,
  output logic [XLEN-1:0]      mem_dout,
  output logic [7:0]           con_data,
  output logic                 con_valid,
  input  logic                 con_ready,
  output logic                 halt,
  output logic [XLEN-1:0]      halt_code,
  output logic                 bus_err
);

  localparam int BYTES = XLEN/8;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]      ram_r [DEPTH];
  logic            halt_r;
  logic [XLEN-1:0] halt_code_r;
  logic            bus_err_r;
  logic            overflow_r;
  logic [XLEN-1:0] cycle_r;

  logic [XLEN-1:0] lane_addr_s [BYTES];
  logic [BYTES-1:0] lane_ram_s;
  logic [BYTES-1:0] lane_unmap_s;
  logic            mmio_s;
  logic [7:0]      ofs_s;
  logic            mmio_wr_s;
  logic            con_push_s;
  logic            con_pop_s;
  logic            con_full_s;
  logic            con_empty_s;
  logic [CW-1:0]   con_count_s;
  logic [XLEN-1:0] status_s;
  logic [XLEN-1:0] mmio_rd_s;

  assign mmio_s     = (mem_addr >= MMIO_BASE);
  assign ofs_s      = {mem_addr[7:2], 2'b00};
  assign mmio_wr_s  = mmio_s && (|mem_w) && !halt_r;
  assign con_push_s = mmio_wr_s && (ofs_s == CONSOLE_OFS) && mem_w[0];
  assign con_pop_s  = con_valid && con_ready;
  assign con_valid  = !con_empty_s;
  assign halt       = halt_r;
  assign halt_code  = halt_code_r;
  assign bus_err    = bus_err_r;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (con_push_s),
    .din   (mem_din[7:0]),
    .pop   (con_pop_s),
    .dout  (con_data),
    .full  (con_full_s),
    .empty (con_empty_s),
    .count (con_count_s)
  );

  // Per-lane address and region classification.
  always_comb begin
    for (int i = 0; i < BYTES; i++) begin
      lane_addr_s[i]  = mem_addr + XLEN'(i);
      lane_ram_s[i]   = !mmio_s && (lane_addr_s[i] < XLEN'(DEPTH));
      lane_unmap_s[i] = !mmio_s && !lane_ram_s[i] && (mem_r[i] || mem_w[i]);
    end
  end

  // MMIO register read mux, including the CONSOLE status word.
  always_comb begin
    status_s                          = '0;
    status_s[ST_FULL_BIT]             = con_full_s;
    status_s[ST_EMPTY_BIT]            = con_empty_s;
    status_s[ST_OVF_BIT]              = overflow_r;
    status_s[ST_COUNT_LSB +: CW]      = con_count_s;
    case (ofs_s)
      TOHOST_OFS:  mmio_rd_s = halt_code_r;
      CONSOLE_OFS: mmio_rd_s = status_s;
      CYCLE_OFS:   mmio_rd_s = cycle_r;
      default:     mmio_rd_s = '0;
    endcase
  end

  // Combinational read data; unstrobed and unmapped lanes read zero.
  always_comb begin
    mem_dout = '0;
    if (mmio_s) begin
      if (|mem_r) begin
        mem_dout = mmio_rd_s;
      end else begin
        mem_dout = '0;
      end
    end else begin
      for (int i = 0; i < BYTES; i++) begin
        if (mem_r[i] && lane_ram_s[i]) begin
          mem_dout[8*i +: 8] = ram_r[lane_addr_s[i][AW-1:0]];
        end else begin
          mem_dout[8*i +: 8] = 8'h00;
        end
      end
    end
  end

  // Byte RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (mem_w[i] && lane_ram_s[i] && !halt_r) begin
        ram_r[lane_addr_s[i][AW-1:0]] <= mem_din[8*i +: 8];
      end
    end
  end

  // Halt, error, overflow flags and the cycle counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halt_r      <= 1'b0;
      halt_code_r <= '0;
      bus_err_r   <= 1'b0;
      overflow_r  <= 1'b0;
      cycle_r     <= '0;
    end else begin
      if (mmio_wr_s && (ofs_s == TOHOST_OFS)) begin
        halt_r      <= 1'b1;
        halt_code_r <= mem_din;
      end
      if (|lane_unmap_s) begin
        bus_err_r <= 1'b1;
      end
      if (con_push_s && con_full_s && !con_pop_s) begin
        overflow_r <= 1'b1;
      end
      if (!halt_r) begin
        cycle_r <= cycle_r + XLEN'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem.sv
// Scoreboard bench for dmem: a driver pushes expected read data computed by a
// byte-array/queue reference model; a negedge monitor pops and compares.
module tb_dmem;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] MMIO  = 32'hFFFF_FF00;
  localparam logic [31:0] A_TOHOST  = 32'hFFFF_FF00;
  localparam logic [31:0] A_CONSOLE = 32'hFFFF_FF04;
  localparam logic [31:0] A_CYCLE   = 32'hFFFF_FF08;

  logic        clk;
  logic        rstn;
  logic [31:0] mem_addr;
  logic [3:0]  mem_r;
  logic [3:0]  mem_w;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;
  logic        halt;
  logic [31:0] halt_code;
  logic        bus_err;

  dmem dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_addr  (mem_addr),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready),
    .halt      (halt),
    .halt_code (halt_code),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  ram_m [DEPTH];
  logic [7:0]  con_q [$];
  logic        halt_m = 1'b0;
  logic [31:0] code_m = 32'd0;
  logic        ovf_m  = 1'b0;
  logic        berr_m = 1'b0;
  logic [31:0] cyc_m  = 32'd0;

  logic [31:0] exp_q [$];
  logic        rd_chk = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [3:0] r);
    logic [31:0] v;
    logic [31:0] la;
    v = 32'd0;
    if (a >= MMIO) begin
      if (r != 4'd0) begin
        case (a[7:2])
          6'd0: v = code_m;
          6'd1: v = (32'(con_q.size()) << 3) | (32'(ovf_m) << 2)
                    | (32'(con_q.size() == 0) << 1) | 32'(con_q.size() == 8);
          6'd2: v = cyc_m;
          default: v = 32'd0;
        endcase
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        la = a + 32'(i);
        if (r[i] && la < 32'(DEPTH)) v[8*i +: 8] = ram_m[la[11:0]];
      end
    end
    return v;
  endfunction

  task automatic model_edge(input logic [31:0] a, input logic [3:0] r,
                            input logic [3:0] w, input logic [31:0] d);
    logic        pop;
    logic        h0;
    logic        accept;
    logic [31:0] la;
    pop    = (con_q.size() > 0) && con_ready;
    h0     = halt_m;
    accept = 1'b0;
    for (int i = 0; i < 4; i++) begin
      la = a + 32'(i);
      if ((r[i] || w[i]) && a < MMIO && la >= 32'(DEPTH)) berr_m = 1'b1;
    end
    if (!h0 && w != 4'd0) begin
      if (a >= MMIO) begin
        if (a[7:2] == 6'd0) begin
          halt_m = 1'b1;
          code_m = d;
        end else if (a[7:2] == 6'd1 && w[0]) begin
          if (con_q.size() < 8 || pop) accept = 1'b1;
          else ovf_m = 1'b1;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          la = a + 32'(i);
          if (w[i] && la < 32'(DEPTH)) ram_m[la[11:0]] = d[8*i +: 8];
        end
      end
    end
    if (pop) void'(con_q.pop_front());
    if (accept) con_q.push_back(d[7:0]);
    if (!h0) cyc_m = cyc_m + 32'd1;
  endtask

  // one bus cycle: drive, predict the read, let the edge happen, update model
  task automatic cycle(input logic [31:0] a, input logic [3:0] r,
                       input logic [3:0] w, input logic [31:0] d);
    mem_addr = a;
    mem_r    = r;
    mem_w    = w;
    mem_din  = d;
    if (r != 4'd0) begin
      exp_q.push_back(model_read(a, r));
      rd_chk = 1'b1;
    end else begin
      rd_chk = 1'b0;
    end
    @(posedge clk);
    model_edge(a, r, w, d);
    #1;
    rd_chk = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(32'd0, 4'd0, 4'd0, 32'd0);
  endtask

  // monitor: compares whatever the DUT presents against the scoreboard/model
  always @(negedge clk) begin
    if (rstn) begin
      if (rd_chk) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_dout: read with empty scoreboard at %0t", $time);
        end else begin
          chk("mem_dout", mem_dout, exp_q.pop_front());
        end
      end
      chk("con_valid", 32'(con_valid), 32'(con_q.size() != 0));
      if (con_valid && con_q.size() != 0) chk("con_data", 32'(con_data), 32'(con_q[0]));
      chk("halt", 32'(halt), 32'(halt_m));
      chk("halt_code", halt_code, code_m);
      chk("bus_err", 32'(bus_err), 32'(berr_m));
    end
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  r;
    logic [3:0]  w;
    logic [31:0] d;
    int          sel;

    rstn = 1'b0;
    mem_addr = 32'd0; mem_r = 4'd0; mem_w = 4'd0; mem_din = 32'd0; con_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("rst_con_data", 32'(con_data), 32'd0);
    chk("rst_halt_code", halt_code, 32'd0);
    cycle(A_CYCLE, 4'hF, 4'd0, 32'd0);
    cycle(A_CONSOLE, 4'hF, 4'd0, 32'd0);

    // fill RAM so every later read has defined model data
    for (int k = 0; k < DEPTH / 4; k++) cycle(32'(4 * k), 4'd0, 4'hF, $urandom);

    // directed store/load and unaligned halfword
    cycle(32'd0, 4'd0, 4'b0001, 32'd123);
    cycle(32'd0, 4'b0001, 4'd0, 32'd0);
    chk("byte_store_model", model_read(32'd0, 4'b0001), 32'h0000_007B);
    cycle(32'd12, 4'd0, 4'b1111, 32'd321);
    cycle(32'd12, 4'b1111, 4'd0, 32'd0);
    cycle(32'd3, 4'd0, 4'b0011, 32'h0000_BEEF);
    cycle(32'd3, 4'b0001, 4'd0, 32'd0);
    cycle(32'd4, 4'b0001, 4'd0, 32'd0);
    cycle(32'd3, 4'b0011, 4'd0, 32'd0);
    chk("halfword_model", model_read(32'd3, 4'b0011), 32'h0000_BEEF);
    // same-cycle read during write returns old data
    cycle(32'd20, 4'hF, 4'hF, 32'hCAFE_F00D);
    cycle(32'd20, 4'hF, 4'd0, 32'd0);
    // lanes crossing the top of RAM
    cycle(32'(DEPTH - 2), 4'hF, 4'd0, 32'd0);

    // console: two pushes, status, then drain
    con_ready = 1'b0;
    cycle(A_CONSOLE, 4'd0, 4'b0001, 32'h48);
    cycle(A_CONSOLE, 4'd0, 4'b0001, 32'h69);
    cycle(A_CONSOLE, 4'hF, 4'd0, 32'd0);
    chk("console_count2", model_read(A_CONSOLE, 4'hF), 32'h0000_0010);
    con_ready = 1'b1;
    idle(3);

    // overflow: push 1..9 without draining
    con_ready = 1'b0;
    for (int k = 1; k <= 9; k++) cycle(A_CONSOLE, 4'd0, 4'b0001, 32'(k));
    cycle(A_CONSOLE, 4'hF, 4'd0, 32'd0);
    chk("overflow_status", model_read(A_CONSOLE, 4'hF), 32'h0000_0045);
    con_ready = 1'b1;
    idle(10);

    // randomized mix of RAM, unmapped and MMIO traffic
    for (int k = 0; k < 600; k++) begin
      sel = $urandom_range(0, 9);
      r = 4'($urandom);
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      d = $urandom;
      con_ready = 1'($urandom);
      if (sel < 5)       a = 32'($urandom_range(0, DEPTH - 1));
      else if (sel == 5) a = 32'($urandom_range(DEPTH - 4, DEPTH - 1));
      else if (sel == 6) a = 32'h0001_0000 + 32'($urandom_range(0, 255));
      else begin
        case ($urandom_range(0, 4))
          0: begin a = A_TOHOST; w = 4'd0; end
          1: a = A_CONSOLE;
          2: a = A_CYCLE;
          3: a = 32'hFFFF_FF0C;
          default: a = 32'hFFFF_FF40;
        endcase
      end
      cycle(a, r, w, d);
    end

    // drain, queue three bytes, raise bus_err, then halt
    con_ready = 1'b1;
    idle(10);
    con_ready = 1'b0;
    cycle(A_CONSOLE, 4'd0, 4'b0001, 32'hA1);
    cycle(A_CONSOLE, 4'd0, 4'b0001, 32'hA2);
    cycle(A_CONSOLE, 4'd0, 4'b0001, 32'hA3);
    cycle(32'h0002_0000, 4'hF, 4'd0, 32'd0);
    cycle(A_TOHOST, 4'd0, 4'b0001, 32'd42);
    cycle(32'd0, 4'd0, 4'hF, 32'hDEAD_BEEF);
    cycle(32'd0, 4'hF, 4'd0, 32'd0);
    cycle(A_TOHOST, 4'hF, 4'd0, 32'd0);
    cycle(A_CYCLE, 4'hF, 4'd0, 32'd0);
    cycle(A_CYCLE, 4'hF, 4'd0, 32'd0);
    cycle(A_CONSOLE, 4'd0, 4'b0001, 32'h55);
    cycle(A_CONSOLE, 4'hF, 4'd0, 32'd0);

    // asynchronous reset in the middle of a cycle
    mem_r = 4'd0; mem_w = 4'd0; mem_addr = 32'd0;
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_con_valid", 32'(con_valid), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_halt_code2", halt_code, 32'd0);
    chk("rst_con_data2", 32'(con_data), 32'd0);
    con_q.delete();
    halt_m = 1'b0; code_m = 32'd0; ovf_m = 1'b0; berr_m = 1'b0; cyc_m = 32'd0;
    rstn = 1'b1;
    cycle(A_CYCLE, 4'hF, 4'd0, 32'd0);
    cycle(A_CONSOLE, 4'hF, 4'd0, 32'd0);
    cycle(32'd0, 4'hF, 4'd0, 32'd0);
    cycle(32'd12, 4'hF, 4'd0, 32'd0);
    cycle(32'd3, 4'b0011, 4'd0, 32'd0);
    cycle(A_CYCLE, 4'hF, 4'd0, 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
